// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - default raster geometry shared by the pong display path
//
// Purpose: single home for the default H/V geometry, pixel divider and sync
//          polarities used by video_timing_gen, the pong top and pixel_gen,
//          plus a width-check helper used at elaboration.
// Ports:   none (package).
package video_timing_gen_pkg;

  localparam int DEF_H_ACTIVE  = 128;
  localparam int DEF_H_FP      = 2;
  localparam int DEF_H_SYNC    = 4;
  localparam int DEF_H_BP      = 4;
  localparam int DEF_V_ACTIVE  = 64;
  localparam int DEF_V_FP      = 2;
  localparam int DEF_V_SYNC    = 4;
  localparam int DEF_V_BP      = 4;
  localparam int DEF_DIV       = 2;
  localparam int DEF_HSYNC_POL = 1;
  localparam int DEF_VSYNC_POL = 1;

  // True when an unsigned field of 'width' bits can hold 'value'.
  function automatic bit fits_width(input int width, input int value);
    return (width >= 1) && (width < 31) && (value >= 0) && (value < (1 << width));
  endfunction

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// rtl/video_timing_gen_axis_counter.sv - one raster axis: wrap counter with active/sync decode
//
// Purpose: counts 0..TOTAL-1 on inc, wraps to 0; load reloads TOTAL-1 (the
//          idle back-porch position). Decodes active region and sync pulse.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (to TOTAL-1)
//   inc          advance by one position
//   load         synchronous reload to TOTAL-1, wins over inc
//   cnt          current position
//   wrap         inc && cnt==TOTAL-1 (still visible when load is high)
//   active       cnt < ACTIVE
//   sync         POL inside [ACTIVE+FP, ACTIVE+FP+SYNC), ~POL elsewhere
module axis_counter
  import video_timing_gen_pkg::*;
#(
  parameter int   TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP,
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter logic POL    = 1'b1,
  parameter int   W      = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap = inc && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LAST;
    end else if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign active = (cnt_q < ACT_END);
  assign sync   = ((cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END)) ? POL : !POL;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing generator for the pong display
//
// Purpose: pixel-enable divider, H/V axis counters with porches and sync,
//          frame counter and line/frame pulses. Raster idles at the last
//          back-porch position so the first pixel enable starts a frame.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   en           run enable; low freezes divider and counters
//   restart      synchronous return to the reset raster position
//   p_tick       pixel enable (combinational, one clk wide)
//   x, y         current column / line
//   vid_on       inside the visible area
//   hsync/vsync  sync outputs at HSYNC_POL/VSYNC_POL
//   line_tick    p_tick on the last column
//   frame_tick   line_tick on the last line
//   frame_cnt    frames started, modulo 2^FCNT_WIDTH
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int DIV         = DEF_DIV,
  parameter int HSYNC_POL   = DEF_HSYNC_POL,
  parameter int VSYNC_POL   = DEF_VSYNC_POL,
  parameter int X_BIT_WIDTH = 9,
  parameter int Y_BIT_WIDTH = 8,
  parameter int FCNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   restart,
  output logic                   p_tick,
  output logic [X_BIT_WIDTH-1:0] x,
  output logic [Y_BIT_WIDTH-1:0] y,
  output logic                   vid_on,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   line_tick,
  output logic                   frame_tick,
  output logic [FCNT_WIDTH-1:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  if ((H_BP < 1) || (V_BP < 1) || (DIV < 1) ||
      !fits_width(X_BIT_WIDTH, H_TOTAL - 1) ||
      !fits_width(Y_BIT_WIDTH, V_TOTAL - 1) ||
      (FCNT_WIDTH < 1)) begin : g_bad_params
    $error("video_timing_gen: illegal geometry, divider or width parameters");
  end

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                  h_active, v_active;

  assign p_tick = en && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (restart || p_tick) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // A frame_tick coinciding with restart is discarded: the raster is
  // pulled back to its idle position, so no new frame has started.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_tick && !restart) begin
      frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  axis_counter #(
    .TOTAL (H_TOTAL),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .POL   (HSYNC_POL != 0),
    .W     (X_BIT_WIDTH)
  ) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .inc   (p_tick),
    .load  (restart),
    .cnt   (x),
    .wrap  (line_tick),
    .active(h_active),
    .sync  (hsync)
  );

  // V advances on the H wrap, so its wrap is exactly the frame_tick.
  axis_counter #(
    .TOTAL (V_TOTAL),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .POL   (VSYNC_POL != 0),
    .W     (Y_BIT_WIDTH)
  ) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .inc   (line_tick),
    .load  (restart),
    .cnt   (y),
    .wrap  (frame_tick),
    .active(v_active),
    .sync  (vsync)
  );

  assign vid_on    = h_active && v_active;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen
module tb_video_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, div, fw, hp, vp;
  } geom_t;

  typedef struct {
    int x, y, div, fcnt;
  } st_t;

  logic       clk;
  logic [2:0] rst_v, en_v, rs_v;

  logic       a_p_tick, a_vid_on, a_hsync, a_vsync, a_line_tick, a_frame_tick;
  logic [8:0] a_x;
  logic [7:0] a_y, a_frame_cnt;
  logic       b_p_tick, b_vid_on, b_hsync, b_vsync, b_line_tick, b_frame_tick;
  logic [8:0] b_x;
  logic [7:0] b_y, b_frame_cnt;
  logic       c_p_tick, c_vid_on, c_hsync, c_vsync, c_line_tick, c_frame_tick;
  logic [2:0] c_x, c_y;
  logic [7:0] c_frame_cnt;

  int          checks = 0;
  int          errors = 0;
  geom_t       g[3];
  st_t         st[3];
  logic [53:0] exp_q[$];
  logic [53:0] last_got;

  video_timing_gen dut_a (
    .clk(clk), .reset(rst_v[0]), .en(en_v[0]), .restart(rs_v[0]),
    .p_tick(a_p_tick), .x(a_x), .y(a_y), .vid_on(a_vid_on), .hsync(a_hsync),
    .vsync(a_vsync), .line_tick(a_line_tick), .frame_tick(a_frame_tick),
    .frame_cnt(a_frame_cnt)
  );

  video_timing_gen #(.DIV(1), .HSYNC_POL(0), .VSYNC_POL(0)) dut_b (
    .clk(clk), .reset(rst_v[1]), .en(en_v[1]), .restart(rs_v[1]),
    .p_tick(b_p_tick), .x(b_x), .y(b_y), .vid_on(b_vid_on), .hsync(b_hsync),
    .vsync(b_vsync), .line_tick(b_line_tick), .frame_tick(b_frame_tick),
    .frame_cnt(b_frame_cnt)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .DIV(1), .X_BIT_WIDTH(3), .Y_BIT_WIDTH(3), .FCNT_WIDTH(8)
  ) dut_c (
    .clk(clk), .reset(rst_v[2]), .en(en_v[2]), .restart(rs_v[2]),
    .p_tick(c_p_tick), .x(c_x), .y(c_y), .vid_on(c_vid_on), .hsync(c_hsync),
    .vsync(c_vsync), .line_tick(c_line_tick), .frame_tick(c_frame_tick),
    .frame_cnt(c_frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic st_t reset_st(input geom_t gg);
    st_t s;
    s.x    = gg.ha + gg.hf + gg.hs + gg.hb - 1;
    s.y    = gg.va + gg.vf + gg.vs + gg.vb - 1;
    s.div  = 0;
    s.fcnt = 0;
    return s;
  endfunction

  // Expected output vector for the current state and en:
  // [53]p_tick [52]line_tick [51]frame_tick [50]vid_on [49]hsync [48]vsync
  // [47:32]x [31:16]y [15:0]frame_cnt
  function automatic logic [53:0] exp_out(input st_t s, input bit en, input geom_t gg);
    int   ht, vt;
    logic pt, lt, ft, von, hsv, vsv;
    ht  = gg.ha + gg.hf + gg.hs + gg.hb;
    vt  = gg.va + gg.vf + gg.vs + gg.vb;
    pt  = en && (s.div == gg.div - 1);
    lt  = pt && (s.x == ht - 1);
    ft  = lt && (s.y == vt - 1);
    von = (s.x < gg.ha) && (s.y < gg.va);
    if ((s.x >= gg.ha + gg.hf) && (s.x < gg.ha + gg.hf + gg.hs)) hsv = (gg.hp != 0);
    else hsv = (gg.hp == 0);
    if ((s.y >= gg.va + gg.vf) && (s.y < gg.va + gg.vf + gg.vs)) vsv = (gg.vp != 0);
    else vsv = (gg.vp == 0);
    return {pt, lt, ft, von, hsv, vsv, 16'(s.x), 16'(s.y), 16'(s.fcnt)};
  endfunction

  function automatic st_t next_st(input st_t s, input bit en, input bit rs, input geom_t gg);
    st_t n;
    int  ht, vt;
    n  = s;
    ht = gg.ha + gg.hf + gg.hs + gg.hb;
    vt = gg.va + gg.vf + gg.vs + gg.vb;
    if (rs) begin
      n.x   = ht - 1;
      n.y   = vt - 1;
      n.div = 0;
    end else if (en) begin
      if (s.div == gg.div - 1) begin
        n.div = 0;
        if (s.x == ht - 1) begin
          n.x = 0;
          if (s.y == vt - 1) begin
            n.y    = 0;
            n.fcnt = (s.fcnt + 1) % (1 << gg.fw);
          end else begin
            n.y = s.y + 1;
          end
        end else begin
          n.x = s.x + 1;
        end
      end else begin
        n.div = s.div + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [53:0] dut_vec(input int d);
    logic [53:0] v;
    v = '0;
    case (d)
      0: v = {a_p_tick, a_line_tick, a_frame_tick, a_vid_on, a_hsync, a_vsync,
              16'(a_x), 16'(a_y), 16'(a_frame_cnt)};
      1: v = {b_p_tick, b_line_tick, b_frame_tick, b_vid_on, b_hsync, b_vsync,
              16'(b_x), 16'(b_y), 16'(b_frame_cnt)};
      default: v = {c_p_tick, c_line_tick, c_frame_tick, c_vid_on, c_hsync, c_vsync,
                    16'(c_x), 16'(c_y), 16'(c_frame_cnt)};
    endcase
    return v;
  endfunction

  // One clk of stimulus on DUT d (others frozen with en=0), called at negedge.
  task automatic step(input int d, input bit en, input bit rs, input string tag);
    logic [53:0] e;
    logic [53:0] got;
    en_v    = '0;
    rs_v    = '0;
    en_v[d] = en;
    rs_v[d] = rs;
    exp_q.push_back(exp_out(st[d], en, g[d]));
    #1;
    got      = dut_vec(d);
    e        = exp_q.pop_front();
    last_got = got;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got=%h expected=%h", tag, d, $time, got, e);
    end
    @(posedge clk);
    st[d] = next_st(st[d], en, rs, g[d]);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({a_x, a_y, a_frame_cnt} !== {9'd137, 8'd73, 8'd0}) begin
      errors++;
      $display("FAIL reset_pos: got x=%0d y=%0d fc=%0d, expected x=137 y=73 fc=0", a_x, a_y, a_frame_cnt);
    end
    checks++;
    if ({a_vid_on, a_hsync, a_vsync, a_line_tick, a_frame_tick, a_p_tick} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 000000",
               {a_vid_on, a_hsync, a_vsync, a_line_tick, a_frame_tick, a_p_tick});
    end
    rst_v = '0;
    step(0, 1'b1, 1'b0, "first_cycle");
    checks++;
    if (last_got[53] !== 1'b0) begin
      errors++;
      $display("FAIL first_no_ptick: got %b expected 0", last_got[53]);
    end
    step(0, 1'b1, 1'b0, "first_ptick");
    checks++;
    if (last_got[53:51] !== 3'b111) begin
      errors++;
      $display("FAIL first_frame_tick: got %b expected 111", last_got[53:51]);
    end
    checks++;
    if ({a_x, a_y, a_vid_on, a_frame_cnt} !== {9'd0, 8'd0, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL first_pixel: got x=%0d y=%0d von=%b fc=%0d, expected 0 0 1 1",
               a_x, a_y, a_vid_on, a_frame_cnt);
    end
  endtask

  task automatic test_frame_period();
    int n;
    n = 0;
    do begin
      step(0, 1'b1, 1'b0, "period_run");
      n++;
    end while (!last_got[51] && n < 30000);
    checks++;
    if (n != 20424) begin
      errors++;
      $display("FAIL frame_period: got %0d clks expected 20424", n);
    end
  endtask

  task automatic test_sync_decode();
    int hs_pix, bad_hs, vs_lines, bad_vs, von_pix;
    hs_pix = 0; bad_hs = 0; vs_lines = 0; bad_vs = 0; von_pix = 0;
    for (int i = 0; i < 20424; i++) begin
      step(0, 1'b1, 1'b0, "sync_run");
      if (last_got[53] && last_got[49]) begin
        hs_pix++;
        if (last_got[47:32] < 16'd130 || last_got[47:32] > 16'd133) bad_hs++;
      end
      if (last_got[53] && last_got[50]) von_pix++;
      if (last_got[52] && last_got[48]) begin
        vs_lines++;
        if (last_got[31:16] < 16'd66 || last_got[31:16] > 16'd69) bad_vs++;
      end
    end
    checks++;
    if (hs_pix != 296 || bad_hs != 0) begin
      errors++;
      $display("FAIL hsync_window: got %0d pix (%0d outside) expected 296 (0)", hs_pix, bad_hs);
    end
    checks++;
    if (vs_lines != 4 || bad_vs != 0) begin
      errors++;
      $display("FAIL vsync_window: got %0d lines (%0d outside) expected 4 (0)", vs_lines, bad_vs);
    end
    checks++;
    if (von_pix != 8192) begin
      errors++;
      $display("FAIL vid_on_area: got %0d expected 8192", von_pix);
    end
  endtask

  task automatic test_en_hold();
    int n, pt_cnt, drift;
    logic [15:0] y0;
    n = 0;
    do begin
      step(0, 1'b1, 1'b0, "seek_x50");
      n++;
    end while (last_got[47:32] != 16'd50 && n < 400);
    y0 = last_got[31:16];
    pt_cnt = 0; drift = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1'b0, 1'b0, "en_low");
      if (last_got[53]) pt_cnt++;
      if (last_got[47:32] != 16'd50 || last_got[31:16] != y0) drift++;
    end
    checks++;
    if (pt_cnt != 0 || drift != 0) begin
      errors++;
      $display("FAIL en_hold: got %0d ticks %0d drift expected 0 0", pt_cnt, drift);
    end
    step(0, 1'b1, 1'b0, "resume");
    checks++;
    if (last_got[53] !== 1'b1) begin
      errors++;
      $display("FAIL resume_div_held: got p_tick=%b expected 1", last_got[53]);
    end
    step(0, 1'b1, 1'b0, "resume_next");
    checks++;
    if (last_got[47:32] !== 16'd51) begin
      errors++;
      $display("FAIL resume_x: got %0d expected 51", last_got[47:32]);
    end
  endtask

  task automatic test_restart();
    int fc_exp;
    step(0, 1'b1, 1'b1, "restart_load");
    fc_exp = st[0].fcnt;
    step(0, 1'b1, 1'b0, "restart_div1");
    step(0, 1'b1, 1'b1, "restart_on_ftick");
    checks++;
    if (last_got[51] !== 1'b1) begin
      errors++;
      $display("FAIL restart_ftick_visible: got %b expected 1", last_got[51]);
    end
    checks++;
    if ({a_x, a_y, a_frame_cnt} !== {9'd137, 8'd73, 8'(fc_exp)}) begin
      errors++;
      $display("FAIL restart_hold: got x=%0d y=%0d fc=%0d expected 137 73 %0d",
               a_x, a_y, a_frame_cnt, fc_exp);
    end
    step(0, 1'b1, 1'b0, "restart_after");
    checks++;
    if (last_got[53] !== 1'b0) begin
      errors++;
      $display("FAIL restart_div_zero: got p_tick=%b expected 0", last_got[53]);
    end
  endtask

  task automatic test_div1_neg_pol();
    int pts, hs_low, bad_hs, vs_low, bad_vs;
    pts = 0; hs_low = 0; bad_hs = 0; vs_low = 0; bad_vs = 0;
    for (int i = 0; i < 10212; i++) begin
      step(1, 1'b1, 1'b0, "div1_run");
      if (last_got[53]) pts++;
      if (last_got[53] && !last_got[49]) begin
        hs_low++;
        if (last_got[47:32] < 16'd130 || last_got[47:32] > 16'd133) bad_hs++;
      end
      if (last_got[52] && !last_got[48]) begin
        vs_low++;
        if (last_got[31:16] < 16'd66 || last_got[31:16] > 16'd69) bad_vs++;
      end
    end
    checks++;
    if (pts != 10212) begin
      errors++;
      $display("FAIL div1_ptick_rate: got %0d expected 10212", pts);
    end
    checks++;
    if (hs_low != 296 || bad_hs != 0 || vs_low != 4 || bad_vs != 0) begin
      errors++;
      $display("FAIL neg_pol_windows: got hs=%0d/%0d vs=%0d/%0d expected 296/0 4/0",
               hs_low, bad_hs, vs_low, bad_vs);
    end
    for (int i = 0; i < 500; i++) step(1, 1'b1, 1'b0, "div1_mid");
    en_v[1] = 1'b1;
    #2;
    rst_v[1] = 1'b1;
    #1;
    checks++;
    if ({b_x, b_y, b_hsync, b_vsync, b_frame_cnt} !== {9'd137, 8'd73, 1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d hs=%b vs=%b fc=%0d expected 137 73 1 1 0",
               b_x, b_y, b_hsync, b_vsync, b_frame_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst_v[1] = 1'b0;
    st[1] = reset_st(g[1]);
    for (int i = 0; i < 200; i++) step(1, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_fcnt_wrap();
    int n, fts;
    n = 0; fts = 0;
    do begin
      step(2, 1'b1, 1'b0, "wrap_run");
      n++;
      if (last_got[51]) fts++;
    end while (fts < 256 && n < 13000);
    checks++;
    if (last_got[15:0] !== 16'd255) begin
      errors++;
      $display("FAIL fcnt_before_wrap: got %0d expected 255", last_got[15:0]);
    end
    step(2, 1'b1, 1'b0, "wrap_next");
    checks++;
    if (last_got[15:0] !== 16'd0) begin
      errors++;
      $display("FAIL fcnt_wrap: got %0d expected 0", last_got[15:0]);
    end
  endtask

  initial begin
    rst_v = 3'b111;
    en_v  = '0;
    rs_v  = '0;
    g[0] = '{128, 2, 4, 4, 64, 2, 4, 4, 2, 8, 1, 1};
    g[1] = '{128, 2, 4, 4, 64, 2, 4, 4, 1, 8, 0, 0};
    g[2] = '{4, 1, 1, 1, 4, 1, 1, 1, 1, 8, 1, 1};
    for (int d = 0; d < 3; d++) st[d] = reset_st(g[d]);
    test_reset();
    test_frame_period();
    test_sync_decode();
    test_en_hold();
    test_restart();
    test_div1_neg_pol();
    test_fcnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
